// File: rtl/fir_chain_ctrl.sv
// ---------------------------------------------------------------------------
// fir_chain_ctrl - coefficient load, flush and sample-streaming sequencer for a
// systolic FIR tap chain. Build option FIR_CTRL_SAT_EN: saturating m_data. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_chain_ctrl #(
  parameter int NTAPS   = 8,
  parameter int LATENCY = 6,
  parameter int OUT_W   = 16
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [7:0]       cfg_data,
  output logic             cfg_ready,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [7:0]       fir_tap,
  output logic [7:0]       fir_h,
  output logic             fir_coeff_load,
  input  logic [39:0]      fir_result,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  output logic             busy,
  output logic             coeffs_ok,
  output logic             sat_flag
);

  localparam int FLUSH_CYC = 2 * NTAPS + LATENCY;
  localparam int CNT_W     = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LATENCY-1:0] vsr_q;
  logic [7:0]         fir_tap_q;
  logic [7:0]         fir_h_q;
  logic               coeff_load_q;
  logic               m_valid_q;
  logic [OUT_W-1:0]   m_data_q;
  logic               coeffs_ok_q;

  logic               accept;
  logic               capture;
  logic [OUT_W-1:0]   narrow_d;

  assign s_ready   = (state_q == RUN) && !cfg_start;
  assign accept    = s_ready && s_valid;
  // A reload request on the capture edge drops the result along with the rest of the pipe.
  assign capture   = (state_q == RUN) && !cfg_start && vsr_q[LATENCY-1];

  assign cfg_ready      = (state_q == LOAD);
  assign busy           = (state_q == LOAD) || (state_q == FLUSH);
  assign fir_tap        = fir_tap_q;
  assign fir_h          = fir_h_q;
  assign fir_coeff_load = coeff_load_q;
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign coeffs_ok      = coeffs_ok_q;

`ifdef FIR_CTRL_SAT_EN
  localparam logic signed [39:0] SAT_MAX = (40'sd1 <<< (OUT_W - 1)) - 40'sd1;
  localparam logic signed [39:0] SAT_MIN = -(40'sd1 <<< (OUT_W - 1));

  logic clamp_d;
  logic sat_flag_q;

  always_comb begin
    clamp_d  = 1'b1;
    narrow_d = fir_result[OUT_W-1:0];
    if ($signed(fir_result) > SAT_MAX) begin
      narrow_d = SAT_MAX[OUT_W-1:0];
    end else if ($signed(fir_result) < SAT_MIN) begin
      narrow_d = SAT_MIN[OUT_W-1:0];
    end else begin
      clamp_d = 1'b0;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      sat_flag_q <= 1'b0;
    end else if (capture && clamp_d) begin
      sat_flag_q <= 1'b1;
    end
  end

  assign sat_flag = sat_flag_q;
`else
  assign narrow_d = fir_result[OUT_W-1:0];
  assign sat_flag = 1'b0;

  generate
    if (OUT_W < 40) begin : g_unused_hi
      logic unused_result_hi;
      assign unused_result_hi = ^fir_result[39:OUT_W];
    end
  endgenerate
`endif

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vsr_q        <= '0;
      fir_tap_q    <= '0;
      fir_h_q      <= '0;
      coeff_load_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      coeffs_ok_q  <= 1'b0;
    end else begin
      coeff_load_q <= 1'b0;
      fir_tap_q    <= '0;
      m_valid_q    <= capture;
      if (capture) begin
        m_data_q <= narrow_d;
      end
      for (int i = LATENCY - 1; i > 0; i--) begin
        vsr_q[i] <= vsr_q[i-1];
      end
      vsr_q[0] <= accept;

      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end
        end
        LOAD: begin
          vsr_q <= '0;
          if (cfg_valid) begin
            fir_h_q      <= cfg_data;
            coeff_load_q <= 1'b1;
            if (cnt_q == CNT_W'(NTAPS - 1)) begin
              state_q <= FLUSH;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          // Zeros are pushed long enough to drain both shift chains plus the result pipe.
          vsr_q <= '0;
          if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            coeffs_ok_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (cfg_start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            vsr_q   <= '0;
          end else if (accept) begin
            fir_tap_q <= s_data;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_chain_ctrl - randomized bench for fir_chain_ctrl with an event-level
// reference model, per-cycle output comparison and directed literal checks. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir_chain_ctrl;

  localparam int NTAPS   = 8;
  localparam int LATENCY = 6;
  localparam int OUT_W   = 16;
  localparam int F_CYC   = 2 * NTAPS + LATENCY;

  logic             iclk;
  logic             irst;
  logic             cfg_start;
  logic             cfg_valid;
  logic [7:0]       cfg_data;
  logic             cfg_ready;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_ready;
  logic [7:0]       fir_tap;
  logic [7:0]       fir_h;
  logic             fir_coeff_load;
  logic [39:0]      fir_result;
  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic             busy;
  logic             coeffs_ok;
  logic             sat_flag;

  int checks = 0;
  int errors = 0;

  fir_chain_ctrl #(.NTAPS(NTAPS), .LATENCY(LATENCY), .OUT_W(OUT_W)) dut (
    .iclk(iclk), .irst(irst),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_tap(fir_tap), .fir_h(fir_h), .fir_coeff_load(fir_coeff_load),
    .fir_result(fir_result),
    .m_valid(m_valid), .m_data(m_data),
    .busy(busy), .coeffs_ok(coeffs_ok), .sat_flag(sat_flag)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge iclk);
    #1;
  endtask

  // Stand-in for the tap chain: h0=1 passes each accepted sample through after LATENCY edges.
  logic [7:0]  hist [LATENCY];
  logic [39:0] fr_rand;
  logic [39:0] fr_fixed;
  int          fr_mode;

  always @(posedge iclk) begin
    hist[0] <= (s_valid && s_ready) ? s_data : 8'h00;
    for (int i = 1; i < LATENCY; i++) hist[i] <= hist[i-1];
    fr_rand <= {8'($urandom), $urandom};
  end

  assign fir_result = (fr_mode == 0) ? {{32{hist[LATENCY-1][7]}}, hist[LATENCY-1]} :
                      (fr_mode == 1) ? fr_rand : fr_fixed;

  // Reference model: counts words and edges, schedules each result LATENCY edges after its accept.
  function automatic logic [OUT_W-1:0] narrow(input logic [39:0] r, output bit clamped);
`ifdef FIR_CTRL_SAT_EN
    longint v;
    longint lim;
    v   = longint'($signed(r));
    lim = longint'(1) << (OUT_W - 1);
    clamped = 1'b1;
    if (v > lim - 1) return OUT_W'(lim - 1);
    if (v < -lim) return OUT_W'(-lim);
    clamped = 1'b0;
    return OUT_W'(v);
`else
    clamped = 1'b0;
    return r[OUT_W-1:0];
`endif
  endfunction

  localparam int M_IDLE = 0, M_LOAD = 1, M_FLUSH = 2, M_RUN = 3;
  int               m_mode;
  int               m_words;
  longint           m_edge;
  longint           m_flush_end;
  longint           due_q [$];
  logic [7:0]       e_tap, e_h;
  logic             e_load, e_mv, e_ok, e_sat;
  logic [OUT_W-1:0] e_md;
  bit               m_clamped;

  always @(posedge iclk or posedge irst) begin
    if (irst) begin
      m_mode = M_IDLE; m_words = 0; m_edge = 0; m_flush_end = 0;
      due_q.delete();
      e_tap = 0; e_h = 0; e_load = 0; e_mv = 0; e_ok = 0; e_sat = 0; e_md = 0;
    end else begin
      m_edge++;
      e_load = 0;
      e_tap  = 0;
      e_mv   = 0;
      if (m_mode == M_RUN && !cfg_start && due_q.size() > 0 && due_q[0] == m_edge) begin
        e_mv = 1;
        e_md = narrow(fir_result, m_clamped);
        if (m_clamped) e_sat = 1;
        void'(due_q.pop_front());
      end
      case (m_mode)
        M_IDLE: if (cfg_start) begin m_mode = M_LOAD; m_words = 0; end
        M_LOAD: if (cfg_valid) begin
          e_h = cfg_data; e_load = 1; m_words++;
          if (m_words == NTAPS) begin m_mode = M_FLUSH; m_flush_end = m_edge + F_CYC; end
        end
        M_FLUSH: if (m_edge == m_flush_end) begin m_mode = M_RUN; e_ok = 1; end
        default: begin
          if (cfg_start) begin
            m_mode = M_LOAD; m_words = 0; due_q.delete();
          end else if (s_valid) begin
            e_tap = s_data;
            due_q.push_back(m_edge + LATENCY);
          end
        end
      endcase
    end
  end

  always @(negedge iclk) begin
    chk("cfg_ready", cfg_ready, m_mode == M_LOAD);
    chk("busy", busy, m_mode == M_LOAD || m_mode == M_FLUSH);
    chk("s_ready", s_ready, m_mode == M_RUN && !cfg_start);
    chk("fir_tap", fir_tap, e_tap);
    chk("fir_h", fir_h, e_h);
    chk("fir_coeff_load", fir_coeff_load, e_load);
    chk("m_valid", m_valid, e_mv);
    chk("m_data", m_data, e_md);
    chk("coeffs_ok", coeffs_ok, e_ok);
    chk("sat_flag", sat_flag, e_sat);
  end

  // Event recorders for the directed checks.
  int         cyc = 0;
  logic [7:0] h_seen [$];
  logic [OUT_W-1:0] mv_data [$];
  int         mv_cyc [$];
  int         acc_cyc [$];

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (fir_coeff_load) h_seen.push_back(fir_h);
    if (m_valid) begin mv_data.push_back(m_data); mv_cyc.push_back(cyc); end
    if (s_valid && s_ready) acc_cyc.push_back(cyc + 1);
  end

  task automatic clear_rec;
    h_seen.delete(); mv_data.delete(); mv_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic one_sample(input logic [7:0] d);
    s_valid = 1'b1; s_data = d; tick;
    s_valid = 1'b0; repeat (LATENCY + 2) tick;
  endtask

  initial begin
    irst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_data = 0; s_valid = 0; s_data = 0;
    fr_mode = 0; fr_fixed = '0;
    repeat (3) tick;
    chk("rst_busy", busy, 1'b0);
    chk("rst_coeffs_ok", coeffs_ok, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_fir_h", fir_h, 8'h00);
    irst = 1'b0;
    tick;

    // Load 1..NTAPS with gaps between words.
    clear_rec();
    cfg_start = 1'b1; tick; cfg_start = 1'b0;
    chk("load_cfg_ready", cfg_ready, 1'b1);
    for (int i = 1; i <= NTAPS; i++) begin
      if (i % 2 == 1) begin cfg_valid = 1'b0; tick; end
      cfg_valid = 1'b1; cfg_data = 8'(i); tick;
    end
    cfg_valid = 1'b0;
    chk("flush_busy_first", busy, 1'b1);
    repeat (F_CYC - 1) tick;
    chk("flush_busy_last", busy, 1'b1);
    chk("flush_coeffs_ok", coeffs_ok, 1'b0);
    tick;
    chk("run_busy", busy, 1'b0);
    chk("run_coeffs_ok", coeffs_ok, 1'b1);
    chk("load_pulses", h_seen.size(), NTAPS);
    for (int i = 0; i < h_seen.size() && i < NTAPS; i++) chk("load_word", h_seen[i], 8'(i + 1));

    // Reload request collides with a sample while a result is in flight.
    clear_rec();
    s_valid = 1'b1; s_data = 8'd9; tick;
    s_valid = 1'b0; tick;
    cfg_start = 1'b1; s_valid = 1'b1; s_data = 8'h55; #1;
    chk("collide_s_ready", s_ready, 1'b0);
    tick;
    cfg_start = 1'b0; s_valid = 1'b0;
    chk("collide_cfg_ready", cfg_ready, 1'b1);
    chk("collide_busy", busy, 1'b1);
    for (int i = 0; i < NTAPS; i++) begin
      cfg_valid = 1'b1; cfg_data = (i == NTAPS - 1) ? 8'd1 : 8'd0; tick;
    end
    cfg_valid = 1'b0;
    repeat (F_CYC) tick;
    chk("collide_no_output", mv_data.size(), 0);
    chk("collide_accepts", acc_cyc.size(), 1);
    chk("reload_coeffs_ok", coeffs_ok, 1'b1);
    chk("reload_busy", busy, 1'b0);

    // Identity filter: samples 5, -3, 7 back to back.
    clear_rec();
    s_valid = 1'b1;
    s_data = 8'd5;  tick;
    s_data = 8'hFD; tick;
    s_data = 8'd7;  tick;
    s_valid = 1'b0;
    repeat (LATENCY + 3) tick;
    chk("ident_pulses", mv_data.size(), 3);
    if (mv_data.size() >= 3 && acc_cyc.size() >= 3) begin
      chk("ident_d0", mv_data[0], 16'h0005);
      chk("ident_d1", mv_data[1], 16'hFFFD);
      chk("ident_d2", mv_data[2], 16'h0007);
      for (int i = 0; i < 3; i++) chk("ident_latency", mv_cyc[i] - acc_cyc[i], LATENCY);
    end

    // Narrowing of fixed results.
    fr_mode = 2;
`ifdef FIR_CTRL_SAT_EN
    clear_rec();
    fr_fixed = 40'sd40000;
    one_sample(8'd1);
    chk("sat_pos_pulses", mv_data.size(), 1);
    if (mv_data.size() > 0) chk("sat_pos_data", mv_data[0], 16'h7FFF);
    chk("sat_pos_flag", sat_flag, 1'b1);
    clear_rec();
    fr_fixed = -40'sd40000;
    one_sample(8'd1);
    chk("sat_neg_pulses", mv_data.size(), 1);
    if (mv_data.size() > 0) chk("sat_neg_data", mv_data[0], 16'h8000);
`else
    clear_rec();
    fr_fixed = 40'h0000012345;
    one_sample(8'd1);
    chk("wrap_pulses", mv_data.size(), 1);
    if (mv_data.size() > 0) chk("wrap_data", mv_data[0], 16'h2345);
    chk("wrap_sat_flag", sat_flag, 1'b0);
`endif

    // Random traffic with occasional reloads.
    for (int n = 0; n < 3000; n++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = 8'($urandom);
      cfg_start = ($urandom_range(0, 299) == 0);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_data  = 8'($urandom);
      fr_mode   = ($urandom_range(0, 2) == 0) ? 1 : 0;
      tick;
    end

    // Settle into RUN, then reset asynchronously mid-stream.
    cfg_start = 1'b0; s_valid = 1'b0; cfg_valid = 1'b1; fr_mode = 0;
    repeat (NTAPS) tick;
    cfg_valid = 1'b0;
    repeat (F_CYC + 1) tick;
    s_valid = 1'b1; s_data = 8'd3;
    repeat (3) tick;
    chk("pre_rst_coeffs_ok", coeffs_ok, 1'b1);
    #2 irst = 1'b1;
    #1;
    chk("arst_fir_tap", fir_tap, 8'h00);
    chk("arst_fir_h", fir_h, 8'h00);
    chk("arst_coeff_load", fir_coeff_load, 1'b0);
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_m_data", m_data, '0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cfg_ready", cfg_ready, 1'b0);
    chk("arst_s_ready", s_ready, 1'b0);
    chk("arst_coeffs_ok", coeffs_ok, 1'b0);
    chk("arst_sat_flag", sat_flag, 1'b0);
    s_valid = 1'b0;
    tick;
    irst = 1'b0;
    repeat (2) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
